// File: rtl/riscv_regfile.sv
// RV32I integer register file: x0..x(N_REGS-1), x0 hardwired to zero.
// Two registered read ports with a stall hold, one write port, and an
// optional same-cycle write-to-read forward. Outputs come only from flops.

`ifndef XLEN
`define XLEN 32
`endif

module riscv_regfile #(
  parameter int N_REGS     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int RD_BYPASS  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rf_rd_en,
  input  logic [REG_ADDR_W-1:0] i_rf_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rf_rs2_addr,
  output logic [`XLEN-1:0]      o_rf_rs1_data,
  output logic [`XLEN-1:0]      o_rf_rs2_data,
  input  logic                  i_rf_wr_en,
  input  logic [REG_ADDR_W-1:0] i_rf_wr_addr,
  input  logic [`XLEN-1:0]      i_rf_wr_data
);

  localparam int XLEN = `XLEN;
  // Register count in address-width-plus-one bits so addresses compare without sign issues.
  localparam logic [REG_ADDR_W:0] N_REGS_W = (REG_ADDR_W+1)'(N_REGS);

  // Storage for x1..x(N_REGS-1); x0 has no storage and always reads zero.
  logic [XLEN-1:0] mem_r [1:N_REGS-1];

  logic            wr_ok_s;
  logic            byp1_s;
  logic            byp2_s;
  logic [XLEN-1:0] rs1_mem_s;
  logic [XLEN-1:0] rs2_mem_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;

  // Qualify the write: x0 and indices beyond the implemented registers are dropped.
  always_comb begin
    wr_ok_s = i_rf_wr_en
              && (i_rf_wr_addr != {REG_ADDR_W{1'b0}})
              && ({1'b0, i_rf_wr_addr} < N_REGS_W);
  end

  // Forward detection: a live write to the register a port is reading.
  always_comb begin
    byp1_s = (RD_BYPASS != 32'sd0) && wr_ok_s && (i_rf_wr_addr == i_rf_rs1_addr);
    byp2_s = (RD_BYPASS != 32'sd0) && wr_ok_s && (i_rf_wr_addr == i_rf_rs2_addr);
  end

  // AND-OR read mux over the stored registers; x0 and out-of-range indices match nothing and yield zero.
  always_comb begin
    rs1_mem_s = {XLEN{1'b0}};
    rs2_mem_s = {XLEN{1'b0}};
    for (int i = 1; i < N_REGS; i++) begin
      rs1_mem_s = rs1_mem_s | ({XLEN{i_rf_rs1_addr == REG_ADDR_W'(i)}} & mem_r[i]);
      rs2_mem_s = rs2_mem_s | ({XLEN{i_rf_rs2_addr == REG_ADDR_W'(i)}} & mem_r[i]);
    end
  end

  // Final read value per port: forwarded write data wins over the pre-edge contents.
  always_comb begin
    if (byp1_s) begin
      rs1_val_s = i_rf_wr_data;
    end else begin
      rs1_val_s = rs1_mem_s;
    end
    if (byp2_s) begin
      rs2_val_s = i_rf_wr_data;
    end else begin
      rs2_val_s = rs2_mem_s;
    end
  end

  // Register array update: async clear, then one qualified write per edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 1; i < N_REGS; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 1; i < N_REGS; i++) begin
        if (wr_ok_s && (i_rf_wr_addr == REG_ADDR_W'(i))) begin
          mem_r[i] <= i_rf_wr_data;
        end
      end
    end
  end

  // Read-data registers: capture on rd_en, otherwise hold through a stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rf_rs1_data <= {XLEN{1'b0}};
      o_rf_rs2_data <= {XLEN{1'b0}};
    end else if (i_rf_rd_en) begin
      o_rf_rs1_data <= rs1_val_s;
      o_rf_rs2_data <= rs2_val_s;
    end else begin
      o_rf_rs1_data <= o_rf_rs1_data;
      o_rf_rs2_data <= o_rf_rs2_data;
    end
  end

endmodule

// File: tb/tb_riscv_regfile.sv
// Directed bench for riscv_regfile. Three instances share one stimulus:
// forwarding enabled, forwarding disabled, and a 24-entry file for
// out-of-range index handling.

module tb_riscv_regfile;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] b1, b2, n1, n2, s1, s2;

  int checks;
  int failures;

  riscv_regfile #(.N_REGS(32), .REG_ADDR_W(5), .RD_BYPASS(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_rf_rd_en(rd_en),
    .i_rf_rs1_addr(rs1), .i_rf_rs2_addr(rs2),
    .o_rf_rs1_data(b1), .o_rf_rs2_data(b2),
    .i_rf_wr_en(wr_en), .i_rf_wr_addr(wr_addr), .i_rf_wr_data(wr_data)
  );

  riscv_regfile #(.N_REGS(32), .REG_ADDR_W(5), .RD_BYPASS(0)) dut_n (
    .i_clk(clk), .i_rst(rst), .i_rf_rd_en(rd_en),
    .i_rf_rs1_addr(rs1), .i_rf_rs2_addr(rs2),
    .o_rf_rs1_data(n1), .o_rf_rs2_data(n2),
    .i_rf_wr_en(wr_en), .i_rf_wr_addr(wr_addr), .i_rf_wr_data(wr_data)
  );

  riscv_regfile #(.N_REGS(24), .REG_ADDR_W(5), .RD_BYPASS(1)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_rf_rd_en(rd_en),
    .i_rf_rs1_addr(rs1), .i_rf_rs2_addr(rs2),
    .o_rf_rs1_data(s1), .o_rf_rs2_data(s2),
    .i_rf_wr_en(wr_en), .i_rf_wr_addr(wr_addr), .i_rf_wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    rd_en    = 1'b0;
    rs1      = 5'd0;
    rs2      = 5'd0;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'h0;
    #1 rst = 1'b1;
    #10;
    chk("reset_rs1", b1, 32'h0);
    chk("reset_rs2", b2, 32'h0);
    rst = 1'b0;

    // Store x5, read it back, then clear with an asynchronous pulse between edges.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    cyc();
    wr_en = 1'b0; rs1 = 5'd5; rs2 = 5'd5; rd_en = 1'b1;
    cyc();
    chk("x5_before_reset", b1, 32'hDEAD_BEEF);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_rs1", b1, 32'h0);
    chk("async_reset_rs2", b2, 32'h0);
    #2 rst = 1'b0;
    cyc();
    chk("x5_after_reset_rs1", b1, 32'h0);
    chk("x5_after_reset_rs2", b2, 32'h0);

    // Plain write then read, with rs2 on x0.
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h1234_5678;
    cyc();
    wr_en = 1'b0; rs1 = 5'd1; rs2 = 5'd0; rd_en = 1'b1;
    cyc();
    chk("x1_read", b1, 32'h1234_5678);
    chk("x0_rs2", b2, 32'h0);

    // Writes to x0 are discarded.
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    cyc();
    wr_en = 1'b0; rs1 = 5'd0; rd_en = 1'b1;
    cyc();
    chk("x0_after_write", b1, 32'h0);

    // Same-edge write and read of x7, old value 0x42.
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0042;
    cyc();
    wr_data = 32'hA5A5_0001; rs1 = 5'd7; rs2 = 5'd7; rd_en = 1'b1;
    cyc();
    chk("bypass_on_rs1", b1, 32'hA5A5_0001);
    chk("bypass_on_rs2", b2, 32'hA5A5_0001);
    chk("bypass_off_rs1", n1, 32'h0000_0042);
    chk("bypass_off_rs2", n2, 32'h0000_0042);
    wr_en = 1'b0;
    cyc();
    chk("bypass_off_next_rs1", n1, 32'hA5A5_0001);
    chk("bypass_off_next_rs2", n2, 32'hA5A5_0001);

    // Stall: capture x3=0x10, write 0x20 while rd_en is low, outputs hold.
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0010;
    cyc();
    wr_en = 1'b0; rs1 = 5'd3; rd_en = 1'b1;
    cyc();
    chk("stall_capture", b1, 32'h0000_0010);
    rd_en = 1'b0; wr_en = 1'b1; wr_data = 32'h0000_0020;
    cyc();
    chk("stall_hold_1", b1, 32'h0000_0010);
    chk("stall_hold_rs2", b2, 32'hA5A5_0001);
    wr_en = 1'b0;
    cyc();
    chk("stall_hold_2", b1, 32'h0000_0010);
    rd_en = 1'b1;
    cyc();
    chk("stall_release", b1, 32'h0000_0020);

    // Two different registers on the two ports.
    rs1 = 5'd1; rs2 = 5'd3;
    cyc();
    chk("dual_rs1", b1, 32'h1234_5678);
    chk("dual_rs2", b2, 32'h0000_0020);

    // Out-of-range index on the 24-entry file: write discarded, read returns 0.
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'hCAFE_0000;
    cyc();
    wr_en = 1'b0; rs1 = 5'd25; rs2 = 5'd1; rd_en = 1'b1;
    cyc();
    chk("oor_small_rs1", s1, 32'h0);
    chk("oor_small_in_range_rs2", s2, 32'h1234_5678);
    chk("oor_full_rs1", b1, 32'hCAFE_0000);

    // Highest implemented index on the 24-entry file still works.
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd23; wr_data = 32'h0BAD_F00D;
    cyc();
    wr_en = 1'b0; rs1 = 5'd23; rd_en = 1'b1;
    cyc();
    chk("top_index_small", s1, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
